// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath.
// The master side is the controller: it consumes the decoded instruction fields
// and the memory acknowledge, and it drives every enable and select.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  // Datapath -> controller
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             mem_ack;

  // Controller -> datapath
  logic [2:0]       state;
  logic             ir_wr;
  logic             pc_wr;
  logic             npc_sel;
  logic             j;
  logic             jal;
  logic             jr;
  logic             reg_wr;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src;
  logic             ext_op;
  logic [2:0]       alu_op;
  logic             mem_req;
  logic             mem_wr;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, funct, mem_ack,
    output state, ir_wr, pc_wr, npc_sel, j, jal, jr, reg_wr, reg_dst,
           mem_to_reg, alu_src, ext_op, alu_op, mem_req, mem_wr, illegal,
           instr_cnt
  );

  modport slave (
    output op, funct, mem_ack,
    input  state, ir_wr, pc_wr, npc_sel, j, jal, jr, reg_wr, reg_dst,
           mem_to_reg, alu_src, ext_op, alu_op, mem_req, mem_wr, illegal,
           instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU. Steps each instruction
// through IF/ID/EXE/MEM/WB, issues per-state enables and selects, handshakes
// with data memory and counts retired instructions (one per pc_wr pulse).
module mc_ctrl #(
  parameter bit MEM_HS = 1'b1,  // 1: MEM waits for mem_ack; 0: MEM is one cycle
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,    // synchronous, active low
  mc_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
  } instr_e;

  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic       npc_sel;
    logic       j;
    logic       jal;
    logic       jr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       mem_req;
    logic       mem_wr;
    logic       illegal;
  } ctl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_e           instr;
  ctl_t             ctl;
  logic             alu_src_x, ext_op_x;
  logic [2:0]       alu_op_x;
  logic             mem_done;

  // Decode op/funct into an instruction class; funct only matters for op 0.
  always_comb begin
    instr = I_ILL;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h21:   instr = I_ADDU;
          6'h23:   instr = I_SUBU;
          6'h08:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      6'h0D:   instr = I_ORI;
      6'h0F:   instr = I_LUI;
      6'h23:   instr = I_LW;
      6'h2B:   instr = I_SW;
      6'h04:   instr = I_BEQ;
      6'h02:   instr = I_J;
      6'h03:   instr = I_JAL;
      default: instr = I_ILL;
    endcase
  end

  // ALU operand/extension controls; shared by EXE and MEM so the load/store
  // address stays stable while the memory access is in flight.
  always_comb begin
    alu_src_x = 1'b0;
    ext_op_x  = 1'b0;
    alu_op_x  = ALU_ADD;
    case (instr)
      I_SUBU: alu_op_x = ALU_SUB;
      I_ORI:  begin alu_src_x = 1'b1; alu_op_x = ALU_OR; end
      I_LUI:  begin alu_src_x = 1'b1; alu_op_x = ALU_LUI; end
      I_LW,
      I_SW:   begin alu_src_x = 1'b1; ext_op_x = 1'b1; end
      I_BEQ:  begin ext_op_x = 1'b1; alu_op_x = ALU_SUB; end
      default: ;
    endcase
  end

  // Next-state and per-state control outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    ctl      = '0;
    mem_done = (MEM_HS == 1'b0) || bus.mem_ack;

    case (state_q)
      S_IF: begin
        ctl.ir_wr = 1'b1;
        state_d   = S_ID;
      end

      S_ID: begin
        case (instr)
          I_J:     begin ctl.pc_wr = 1'b1; ctl.j  = 1'b1;      state_d = S_IF; end
          I_JR:    begin ctl.pc_wr = 1'b1; ctl.jr = 1'b1;      state_d = S_IF; end
          I_ILL:   begin ctl.pc_wr = 1'b1; ctl.illegal = 1'b1; state_d = S_IF; end
          I_JAL:   state_d = S_WB;
          default: state_d = S_EXE;
        endcase
      end

      S_EXE: begin
        ctl.alu_src = alu_src_x;
        ctl.ext_op  = ext_op_x;
        ctl.alu_op  = alu_op_x;
        case (instr)
          I_BEQ: begin
            ctl.npc_sel = 1'b1;
            ctl.pc_wr   = 1'b1;
            state_d     = S_IF;
          end
          I_LW, I_SW:                    state_d = S_MEM;
          I_ADDU, I_SUBU, I_ORI, I_LUI:  state_d = S_WB;
          default:                       state_d = S_IF;
        endcase
      end

      S_MEM: begin
        ctl.alu_src = alu_src_x;
        ctl.ext_op  = ext_op_x;
        ctl.alu_op  = alu_op_x;
        ctl.mem_req = 1'b1;
        ctl.mem_wr  = (instr == I_SW);
        if (mem_done) begin
          if (instr == I_SW) begin
            ctl.pc_wr = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d   = S_WB;
          end
        end
      end

      S_WB: begin
        ctl.reg_wr = 1'b1;
        ctl.pc_wr  = 1'b1;
        state_d    = S_IF;
        case (instr)
          I_ADDU, I_SUBU: begin ctl.reg_dst = DST_RD; ctl.mem_to_reg = WB_ALU; end
          I_LW:           begin ctl.reg_dst = DST_RT; ctl.mem_to_reg = WB_MEM; end
          I_JAL: begin
            ctl.reg_dst    = DST_RA;
            ctl.mem_to_reg = WB_PC4;
            ctl.jal        = 1'b1;
          end
          default:        begin ctl.reg_dst = DST_RT; ctl.mem_to_reg = WB_ALU; end
        endcase
      end

      default: state_d = S_IF;
    endcase

    // Reset holds every enable low, including ir_wr.
    if (!reset) ctl = '0;
  end

  // Retired-instruction count advances on every PC commit and wraps naturally.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(ctl.pc_wr);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.ir_wr      = ctl.ir_wr;
  assign bus.pc_wr      = ctl.pc_wr;
  assign bus.npc_sel    = ctl.npc_sel;
  assign bus.j          = ctl.j;
  assign bus.jal        = ctl.jal;
  assign bus.jr         = ctl.jr;
  assign bus.reg_wr     = ctl.reg_wr;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.alu_src    = ctl.alu_src;
  assign bus.ext_op     = ctl.ext_op;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.mem_req    = ctl.mem_req;
  assign bus.mem_wr     = ctl.mem_wr;
  assign bus.illegal    = ctl.illegal;
  assign bus.instr_cnt  = cnt_q;

endmodule
